// File: rtl/mor1kx_rf_read_cappuccino.sv
// GPR array with two registered read ports, same-cycle write bypass and stall refresh.
// Optional build macro MOR1KX_RF_R0_ZERO_EN hardwires index 0 to zero.
module mor1kx_rf_read_cappuccino #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_RF_ADDR_WIDTH = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            padv_decode_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] rfa_adr_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] rfb_adr_i,
  input  logic                            rf_we_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] rf_wb_adr_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] rf_result_i,
  output logic [OPTION_OPERAND_WIDTH-1:0] rfa_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] rfb_o,
  output logic [OPTION_RF_ADDR_WIDTH-1:0] rfa_adr_o,
  output logic [OPTION_RF_ADDR_WIDTH-1:0] rfb_adr_o
);

  localparam int DEPTH = 1 << OPTION_RF_ADDR_WIDTH;

  logic [OPTION_OPERAND_WIDTH-1:0] mem [DEPTH];

  logic                            wr_ok;
  logic [OPTION_OPERAND_WIDTH-1:0] rd_a;
  logic [OPTION_OPERAND_WIDTH-1:0] rd_b;
  logic [OPTION_OPERAND_WIDTH-1:0] next_a;
  logic [OPTION_OPERAND_WIDTH-1:0] next_b;

  // A write that lands in the array is also the only thing allowed to forward.
`ifdef MOR1KX_RF_R0_ZERO_EN
  assign wr_ok = rf_we_i && (rf_wb_adr_i != '0);
  assign rd_a  = (rfa_adr_i == '0) ? '0 : mem[rfa_adr_i];
  assign rd_b  = (rfb_adr_i == '0) ? '0 : mem[rfb_adr_i];
`else
  assign wr_ok = rf_we_i;
  assign rd_a  = mem[rfa_adr_i];
  assign rd_b  = mem[rfb_adr_i];
`endif

  always_comb begin
    next_a = rfa_o;
    next_b = rfb_o;
    if (padv_decode_i) begin
      next_a = (wr_ok && (rf_wb_adr_i == rfa_adr_i)) ? rf_result_i : rd_a;
      next_b = (wr_ok && (rf_wb_adr_i == rfb_adr_i)) ? rf_result_i : rd_b;
    end else begin
      if (wr_ok && (rf_wb_adr_i == rfa_adr_o)) next_a = rf_result_i;
      if (wr_ok && (rf_wb_adr_i == rfb_adr_o)) next_b = rf_result_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[rf_wb_adr_i] <= rf_result_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rfa_o     <= '0;
      rfb_o     <= '0;
      rfa_adr_o <= '0;
      rfb_adr_o <= '0;
    end else begin
      rfa_o <= next_a;
      rfb_o <= next_b;
      if (padv_decode_i) begin
        rfa_adr_o <= rfa_adr_i;
        rfb_adr_o <= rfb_adr_i;
      end
    end
  end

endmodule

// File: tb/tb_mor1kx_rf_read_cappuccino.sv
// Bench for mor1kx_rf_read_cappuccino: directed scenarios plus random traffic vs. a register-file model.
module tb_mor1kx_rf_read_cappuccino;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        padv_decode_i = 1'b0;
  logic [4:0]  rfa_adr_i = '0;
  logic [4:0]  rfb_adr_i = '0;
  logic        rf_we_i = 1'b0;
  logic [4:0]  rf_wb_adr_i = '0;
  logic [31:0] rf_result_i = '0;
  logic [31:0] rfa_o, rfb_o;
  logic [4:0]  rfa_adr_o, rfb_adr_o;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_arr [32];
  logic [31:0] m_a, m_b;
  logic [4:0]  m_aa, m_ba;

  mor1kx_rf_read_cappuccino dut (
    .clk(clk), .rst(rst), .padv_decode_i(padv_decode_i),
    .rfa_adr_i(rfa_adr_i), .rfb_adr_i(rfb_adr_i),
    .rf_we_i(rf_we_i), .rf_wb_adr_i(rf_wb_adr_i), .rf_result_i(rf_result_i),
    .rfa_o(rfa_o), .rfb_o(rfb_o), .rfa_adr_o(rfa_adr_o), .rfb_adr_o(rfb_adr_o)
  );

  always #5 clk = ~clk;

`ifdef MOR1KX_RF_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_arr[i] = '0;
    m_a = '0; m_b = '0; m_aa = '0; m_ba = '0;
  endfunction

  // Register file semantics: a write is visible to any read that happens in the same cycle.
  function automatic void model_clock(input logic padv, input logic [4:0] a, input logic [4:0] b,
                                      input logic we, input logic [4:0] wb, input logic [31:0] res);
    logic [31:0] view [32];
    bit landed;
    landed = we && !(R0_ZERO && wb == 5'd0);
    for (int i = 0; i < 32; i++) view[i] = m_arr[i];
    if (landed) view[wb] = res;
    if (padv) begin
      m_aa = a; m_ba = b;
      m_a = view[a]; m_b = view[b];
    end else begin
      m_a = view[m_aa]; m_b = view[m_ba];
    end
    for (int i = 0; i < 32; i++) m_arr[i] = view[i];
  endfunction

  task automatic cyc(input logic padv, input logic [4:0] a, input logic [4:0] b,
                     input logic we, input logic [4:0] wb, input logic [31:0] res);
    padv_decode_i = padv; rfa_adr_i = a; rfb_adr_i = b;
    rf_we_i = we; rf_wb_adr_i = wb; rf_result_i = res;
    @(posedge clk);
    model_clock(padv, a, b, we, wb, res);
    #1;
    padv_decode_i = 1'b0; rf_we_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    #3;
    vectors++;
    if (rfa_o !== 32'd0 || rfb_o !== 32'd0 || rfa_adr_o !== 5'd0 || rfb_adr_o !== 5'd0) begin
      miscompares++;
      $display("FAIL reset: rfa=%h rfb=%h adra=%0d adrb=%0d required all 0", rfa_o, rfb_o, rfa_adr_o, rfb_adr_o);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_read();
    cyc(1'b1, 5'd3, 5'd7, 1'b0, 5'd0, 32'd0);
    vectors++;
    if (rfa_o !== 32'd0 || rfb_o !== 32'd0 || rfa_adr_o !== 5'd3 || rfb_adr_o !== 5'd7) begin
      miscompares++;
      $display("FAIL basic_read: rfa=%h rfb=%h adra=%0d adrb=%0d required 0 0 3 7", rfa_o, rfb_o, rfa_adr_o, rfb_adr_o);
    end
  endtask

  task automatic test_write_read();
    cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF);
    cyc(1'b1, 5'd5, 5'd3, 1'b0, 5'd0, 32'd0);
    vectors++;
    if (rfa_o !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL write_read: rfa=%h required deadbeef", rfa_o);
    end
  endtask

  task automatic test_bypass();
    cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd9, 32'h11);
    cyc(1'b1, 5'd9, 5'd9, 1'b1, 5'd9, 32'h22);
    vectors++;
    if (rfa_o !== 32'h22 || rfb_o !== 32'h22) begin
      miscompares++;
      $display("FAIL bypass: rfa=%h rfb=%h required 22 22", rfa_o, rfb_o);
    end
    cyc(1'b1, 5'd9, 5'd1, 1'b0, 5'd0, 32'd0);
    vectors++;
    if (rfa_o !== 32'h22) begin
      miscompares++;
      $display("FAIL bypass_array: rfa=%h required 22", rfa_o);
    end
  endtask

  task automatic test_stall_refresh();
    cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd4, 32'h1);
    cyc(1'b1, 5'd4, 5'd2, 1'b0, 5'd0, 32'd0);
    cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd6, 32'h77);
    vectors++;
    if (rfa_o !== 32'h1 || rfa_adr_o !== 5'd4) begin
      miscompares++;
      $display("FAIL stall_other: rfa=%h adra=%0d required 1 4", rfa_o, rfa_adr_o);
    end
    cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd4, 32'hAB);
    vectors++;
    if (rfa_o !== 32'hAB || rfa_adr_o !== 5'd4) begin
      miscompares++;
      $display("FAIL stall_refresh: rfa=%h adra=%0d required ab 4", rfa_o, rfa_adr_o);
    end
  endtask

  task automatic test_async_reset();
    cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd8, 32'h55);
    cyc(1'b1, 5'd4, 5'd8, 1'b0, 5'd0, 32'd0);
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
    vectors++;
    if (rfb_o !== 32'h55) begin
      miscompares++;
      $display("FAIL stall_hold: rfb=%h required 55", rfb_o);
    end
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (rfb_o !== 32'd0 || rfa_o !== 32'd0 || rfb_adr_o !== 5'd0) begin
      miscompares++;
      $display("FAIL async_reset: rfa=%h rfb=%h adrb=%0d required 0 0 0", rfa_o, rfb_o, rfb_adr_o);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    cyc(1'b1, 5'd4, 5'd8, 1'b0, 5'd0, 32'd0);
    vectors++;
    if (rfa_o !== 32'd0 || rfb_o !== 32'd0) begin
      miscompares++;
      $display("FAIL post_reset_read: rfa=%h rfb=%h required 0 0", rfa_o, rfb_o);
    end
  endtask

  task automatic test_r0();
    logic [31:0] exp0;
    exp0 = R0_ZERO ? 32'd0 : 32'hFFFF_FFFF;
    cyc(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    cyc(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
    vectors++;
    if (rfa_o !== exp0 || rfb_o !== exp0) begin
      miscompares++;
      $display("FAIL r0_read: rfa=%h rfb=%h required %h", rfa_o, rfb_o, exp0);
    end
    cyc(1'b1, 5'd0, 5'd3, 1'b1, 5'd0, 32'h1234_5678);
    exp0 = R0_ZERO ? 32'd0 : 32'h1234_5678;
    vectors++;
    if (rfa_o !== exp0) begin
      miscompares++;
      $display("FAIL r0_bypass: rfa=%h required %h", rfa_o, exp0);
    end
  endtask

  task automatic test_random();
    logic [4:0] a, b, wb;
    for (int n = 0; n < 400; n++) begin
      a  = 5'($urandom_range(0, 7));
      b  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      wb = 5'($urandom_range(0, 7));
      cyc(1'($urandom_range(0, 1)), a, b, 1'($urandom_range(0, 2) != 0), wb, $urandom);
      vectors++;
      if (rfa_o !== m_a || rfb_o !== m_b || rfa_adr_o !== m_aa || rfb_adr_o !== m_ba) begin
        miscompares++;
        $display("FAIL random[%0d]: got a=%h b=%h adra=%0d adrb=%0d required a=%h b=%h adra=%0d adrb=%0d",
                 n, rfa_o, rfb_o, rfa_adr_o, rfb_adr_o, m_a, m_b, m_aa, m_ba);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_write_read();
    test_bypass();
    test_stall_refresh();
    test_async_reset();
    test_r0();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
